mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch unit (master 0, read-only) and the load/store unit (master 1, read/write).
- Uses valid/ready request and response channels.
- Services one transaction at a time; round-robin when both masters request in the same cycle.
- Watchdog returns an error response if the memory never answers.
- Sits between ifu/lsu and the memory-side adapter (DPI pmem or bus bridge).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 1024, maximum cycles to wait for a memory response; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  ADDR_W  IFU fetch address.
- ifu_rsp_valid  out  1  IFU response available.
- ifu_rsp_ready  in  1  IFU consumes response.
- ifu_rsp_rdata  out  DATA_W  fetched word.
- ifu_rsp_err  out  1  timeout error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_wen  in  1  1 = write, 0 = read.
- lsu_req_addr  in  ADDR_W  address.
- lsu_req_wdata  in  DATA_W  write data.
- lsu_req_wmask  in  8  byte write mask.
- lsu_rsp_valid  out  1  LSU response available.
- lsu_rsp_ready  in  1  LSU consumes response.
- lsu_rsp_rdata  out  DATA_W  read data (0 for writes).
- lsu_rsp_err  out  1  timeout error.
- mem_req_valid / mem_req_ready  out/in  1  memory request handshake.
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/ADDR_W/DATA_W/8  latched request.
- mem_rsp_valid / mem_rsp_ready  in/out  1  memory response handshake.
- mem_rsp_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all valid/ready outputs 0; latched request fields, response buffer and error flag 0.
  - last_grant=LSU, so IFU wins the first tie; timeout counter 0; orphan flag 0.
- States: IDLE, REQ, RSP, DONE.
- IDLE:
  - Winner selection: only one master valid → that master; both valid → the master not equal to last_grant.
  - Winner's req_ready=1 combinationally; the loser's req_ready=0.
  - On the handshake: latch addr, wen, wdata, wmask, grant ID (IFU requests force wen=0, wmask=0); update last_grant; next state REQ.
  - While orphan=1: no grants (both req_ready=0); mem_rsp_ready=1; a mem_rsp_valid clears orphan and its data is discarded.
- REQ:
  - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
  - On the handshake: clear counter; next state RSP.
- RSP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid: capture rdata (forced to 0 if wen), err=0; next state DONE.
  - Otherwise the counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without a response: rdata=0, err=1, orphan=1; next state DONE.
  - If response and timeout coincide, the response wins.
- DONE:
  - Granted master's rsp_valid=1 with buffered rdata/err, held until that master's rsp_ready; then IDLE.
  - Non-granted master's rsp_valid=0.
- Latency: minimum 4 cycles from request acceptance to return to IDLE: accept t0, mem request t1, mem response t2, rsp_valid t3.
- Counter is sized clog2(TIMEOUT+1) bits and saturates; it never wraps.
- Requests arriving outside IDLE see req_ready=0; masters must hold valid and fields stable until accepted.
- Reset mid-transaction aborts immediately with no response; memory-side cleanup is the memory adapter's responsibility.
- No combinational path from mem_rsp_* to master rsp_* (response is registered).

Decomposition:
- Shared package: state enum (IDLE/REQ/RSP/DONE), master ID constants (MID_IFU=0, MID_LSU=1), wmask width constant (8).
- One sub-module: rr_arbiter2, a two-requester round-robin grant with last_grant register.
- FSM, latch and watchdog remain in mem_arbiter.

Test Plan:
- IFU read 0x80000000 alone, memory ready immediately, rdata 0x00000413 one cycle later → ifu_rsp_valid at t3 with 0x00000413, err=0; lsu_rsp_valid stays 0.
- IFU and LSU valid same cycle after reset → IFU granted first; LSU write 0x80001000 / data 0xDEADBEEF / wmask 0x0F granted next, appearing on mem_req_* unchanged, lsu_rsp_rdata=0.
- Back-to-back simultaneous requests ×4 → grants alternate IFU, LSU, IFU, LSU.
- mem_req_ready held 0 for 5 cycles → mem_req_* stable throughout; both req_ready=0; completes normally afterwards.
- TIMEOUT=8, memory never responds → rsp_err=1, rdata=0 after 8 RSP cycles; later stray mem_rsp_valid is absorbed in IDLE before the next grant.
- Master holds rsp_ready=0 for 3 cycles in DONE; rst pulsed low mid-RSP → response held stable while waiting; after reset all outputs 0 and state IDLE without a clock edge.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  localparam int WMASK_W = 8;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic advance,
  output logic gnt_ifu,
  output logic gnt_lsu,
  output logic gnt_id
);

  logic last_grant_reg;

  always_comb begin
    gnt_id = MID_IFU;
    if (req_ifu && req_lsu) begin
      gnt_id = ~last_grant_reg;
    end else if (req_lsu) begin
      gnt_id = MID_LSU;
    end
    gnt_ifu = req_ifu && (gnt_id == MID_IFU);
    gnt_lsu = req_lsu && (gnt_id == MID_LSU);
  end

  // Reset to LSU so the IFU wins the very first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= MID_LSU;
    end else if (advance) begin
      last_grant_reg <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU, one transaction at a time,
// with a watchdog that answers with an error if memory never responds.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [ADDR_W-1:0]  ifu_req_addr,
  output logic               ifu_rsp_valid,
  input  logic               ifu_rsp_ready,
  output logic [DATA_W-1:0]  ifu_rsp_rdata,
  output logic               ifu_rsp_err,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic               lsu_req_wen,
  input  logic [ADDR_W-1:0]  lsu_req_addr,
  input  logic [DATA_W-1:0]  lsu_req_wdata,
  input  logic [WMASK_W-1:0] lsu_req_wmask,
  output logic               lsu_rsp_valid,
  input  logic               lsu_rsp_ready,
  output logic [DATA_W-1:0]  lsu_rsp_rdata,
  output logic               lsu_rsp_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_wen,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic [DATA_W-1:0]  mem_req_wdata,
  output logic [WMASK_W-1:0] mem_req_wmask,
  input  logic               mem_rsp_valid,
  output logic               mem_rsp_ready,
  input  logic [DATA_W-1:0]  mem_rsp_rdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t             state_reg;
  logic               grant_reg;
  logic               wen_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [WMASK_W-1:0] wmask_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               err_reg;
  logic               orphan_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic       grant_ok;
  logic       gnt_ifu;
  logic       gnt_lsu;
  logic       gnt_id;
  logic       accept;
  logic [1:0] rsp_valid_vec;
  logic       done_hs;

  // A late response from a timed-out transaction must be drained before anyone is granted.
  assign grant_ok = (state_reg == ST_IDLE) && !orphan_reg;
  assign accept   = gnt_ifu || gnt_lsu;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_ifu (ifu_req_valid && grant_ok),
    .req_lsu (lsu_req_valid && grant_ok),
    .advance (accept),
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu),
    .gnt_id  (gnt_id)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_valid
    assign rsp_valid_vec[gi] = (state_reg == ST_DONE) && (grant_reg == 1'(gi));
  end

  assign done_hs = (rsp_valid_vec[MID_IFU] && ifu_rsp_ready) ||
                   (rsp_valid_vec[MID_LSU] && lsu_rsp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= MID_IFU;
      wen_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      orphan_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (orphan_reg) begin
            if (mem_rsp_valid) orphan_reg <= 1'b0;
          end else if (accept) begin
            grant_reg <= gnt_id;
            state_reg <= ST_REQ;
            if (gnt_id == MID_LSU) begin
              wen_reg   <= lsu_req_wen;
              addr_reg  <= lsu_req_addr;
              wdata_reg <= lsu_req_wdata;
              wmask_reg <= lsu_req_wmask;
            end else begin
              wen_reg   <= 1'b0;
              addr_reg  <= ifu_req_addr;
              wdata_reg <= '0;
              wmask_reg <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            cnt_reg   <= '0;
            state_reg <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rsp_valid) begin
            rdata_reg <= wen_reg ? '0 : mem_rsp_rdata;
            err_reg   <= 1'b0;
            state_reg <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
            rdata_reg  <= '0;
            err_reg    <= 1'b1;
            orphan_reg <= 1'b1;
            state_reg  <= ST_DONE;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (done_hs) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;

  assign ifu_rsp_valid = rsp_valid_vec[MID_IFU];
  assign ifu_rsp_rdata = rdata_reg;
  assign ifu_rsp_err   = err_reg;
  assign lsu_rsp_valid = rsp_valid_vec[MID_LSU];
  assign lsu_rsp_rdata = rdata_reg;
  assign lsu_rsp_err   = err_reg;

  assign mem_req_valid = (state_reg == ST_REQ);
  assign mem_req_wen   = wen_reg;
  assign mem_req_addr  = addr_reg;
  assign mem_req_wdata = wdata_reg;
  assign mem_req_wmask = wmask_reg;
  assign mem_rsp_ready = (state_reg == ST_RSP) || ((state_reg == ST_IDLE) && orphan_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: predicted memory requests and master responses are queued
// at stimulus time and compared when the DUT produces them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_req_addr, ifu_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [7:0]  lsu_req_wmask, mem_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic mid; logic wen; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask; } mreq_t;
  typedef struct { logic mid; logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask; } lreq_t;

  mreq_t       exp_mreq_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] ifu_src_q[$];
  lreq_t       lsu_src_q[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   stray_req_cnt = 0;
  int   stray_done_cnt = 0;
  logic tb_last = MID_LSU;
  logic drop_rsp = 1'b0;
  logic expect_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic void push_rsp(input logic mid, input logic [31:0] d);
    if (expect_timeout) exp_rsp_q.push_back('{mid: mid, rdata: 32'd0, err: 1'b1, lat: TMO + 1});
    else                exp_rsp_q.push_back('{mid: mid, rdata: d, err: 1'b0, lat: 2});
  endfunction

  function automatic void push_ifu(input logic [31:0] a);
    exp_mreq_q.push_back('{mid: MID_IFU, wen: 1'b0, addr: a, wdata: 32'd0, wmask: 8'd0});
    push_rsp(MID_IFU, mem_word(a));
  endfunction

  function automatic void push_lsu(input lreq_t r);
    exp_mreq_q.push_back('{mid: MID_LSU, wen: r.wen, addr: r.addr, wdata: r.wdata, wmask: r.wmask});
    push_rsp(MID_LSU, r.wen ? 32'd0 : mem_word(r.addr));
  endfunction

  // Memory model: one-cycle response after each accepted request, plus injected stray responses.
  initial begin
    logic        hs;
    logic [31:0] rsp_word;
    mreq_t       em;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    rsp_word = '0;
    forever begin
      @(negedge clk);
      hs = rst && mem_req_valid && mem_req_ready;
      if (hs) begin
        hs_cyc = cyc;
        check_eq("mreq_expected", 64'(exp_mreq_q.size() != 0), 64'd1);
        if (exp_mreq_q.size() != 0) begin
          em = exp_mreq_q.pop_front();
          check_eq("mreq_wen", 64'(mem_req_wen), 64'(em.wen));
          check_eq("mreq_addr", 64'(mem_req_addr), 64'(em.addr));
          check_eq("mreq_wmask", 64'(mem_req_wmask), 64'(em.wmask));
          if (em.mid == MID_LSU) check_eq("mreq_wdata", 64'(mem_req_wdata), 64'(em.wdata));
        end
        rsp_word = mem_word(mem_req_addr);
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      if (hs && !drop_rsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_word;
      end else if (stray_req_cnt != stray_done_cnt) begin
        stray_done_cnt++;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Response monitor: latency on first valid, contents on handshake.
  initial begin
    logic prev_v = 1'b0;
    logic any_v;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        any_v = ifu_rsp_valid || lsu_rsp_valid;
        if (any_v && !prev_v) begin
          check_eq("rsp_onehot", 64'(ifu_rsp_valid && lsu_rsp_valid), 64'd0);
          check_eq("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
          if (exp_rsp_q.size() != 0) check_eq("rsp_latency", 64'(cyc - hs_cyc), 64'(exp_rsp_q[0].lat));
        end
        if (((ifu_rsp_valid && ifu_rsp_ready) || (lsu_rsp_valid && lsu_rsp_ready)) && exp_rsp_q.size() != 0) begin
          e = exp_rsp_q.pop_front();
          check_eq("rsp_mid", 64'(lsu_rsp_valid), 64'(e.mid));
          check_eq("rsp_rdata", 64'(lsu_rsp_valid ? lsu_rsp_rdata : ifu_rsp_rdata), 64'(e.rdata));
          check_eq("rsp_err", 64'(lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err), 64'(e.err));
          $display("rsp %s rdata=0x%08h err=%0d cyc=%0d", lsu_rsp_valid ? "lsu" : "ifu",
                   lsu_rsp_valid ? lsu_rsp_rdata : ifu_rsp_rdata,
                   lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err, cyc);
        end
        prev_v = any_v;
      end
    end
  end

  // Predicts grant order from the queued sources, then keeps each master's next request presented.
  task automatic run_stream();
    int   ni, nl, pi, pl, ii, li, budget;
    logic pick, acc_i, acc_l;
    ni = ifu_src_q.size();
    nl = lsu_src_q.size();
    pi = 0;
    pl = 0;
    while (pi < ni || pl < nl) begin
      if (pi < ni && pl < nl) pick = ~tb_last;
      else                    pick = (pi < ni) ? MID_IFU : MID_LSU;
      if (pick == MID_IFU) begin push_ifu(ifu_src_q[pi]); pi++; end
      else                 begin push_lsu(lsu_src_q[pl]); pl++; end
      tb_last = pick;
    end
    ii = 0;
    li = 0;
    budget = 0;
    while ((ii < ni || li < nl) && budget < 400) begin
      ifu_req_valid = (ii < ni);
      if (ii < ni) ifu_req_addr = ifu_src_q[ii];
      lsu_req_valid = (li < nl);
      if (li < nl) begin
        lsu_req_wen   = lsu_src_q[li].wen;
        lsu_req_addr  = lsu_src_q[li].addr;
        lsu_req_wdata = lsu_src_q[li].wdata;
        lsu_req_wmask = lsu_src_q[li].wmask;
      end
      @(negedge clk);
      acc_i = ifu_req_valid && ifu_req_ready;
      acc_l = lsu_req_valid && lsu_req_ready;
      if (acc_i || acc_l) check_eq("req_ready_onehot", 64'(acc_i && acc_l), 64'd0);
      @(posedge clk); #1;
      if (acc_i) ii++;
      if (acc_l) li++;
      budget++;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    check_eq("stream_accepted", 64'(ii + li), 64'(ni + nl));
    ifu_src_q.delete();
    lsu_src_q.delete();
  endtask

  task automatic wait_drain();
    int b = 0;
    while (exp_rsp_q.size() != 0 && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check_eq("drain", 64'(exp_rsp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_idle(input string tag);
    check_eq({tag, "_ctrl"}, 64'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                  mem_req_valid, mem_rsp_ready}), 64'd0);
    check_eq({tag, "_mreq"}, {mem_req_addr, mem_req_wdata}, 64'd0);
    check_eq({tag, "_flags"}, 64'({mem_req_wen, mem_req_wmask, ifu_rsp_err, lsu_rsp_err}), 64'd0);
    check_eq({tag, "_rdata"}, {ifu_rsp_rdata, lsu_rsp_rdata}, 64'd0);
  endtask

  initial begin
    int b;
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b1;
    lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0;
    lsu_req_wmask = '0; lsu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_idle("reset");
    rst = 1'b1;

    // Simultaneous after reset: IFU first, then the LSU write passes through unchanged.
    ifu_src_q.push_back(32'h8000_0010);
    lsu_src_q.push_back('{wen: 1'b1, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF, wmask: 8'h0F});
    run_stream();
    wait_drain();

    ifu_src_q.push_back(32'h8000_0000);
    run_stream();
    wait_drain();

    for (int k = 0; k < 4; k++) begin
      ifu_src_q.push_back(32'h8000_0100 + 32'(k * 4));
      lsu_src_q.push_back('{wen: k[0], addr: 32'h8000_2000 + 32'(k * 16), wdata: $urandom, wmask: 8'hF0 | 8'(k)});
    end
    run_stream();
    wait_drain();

    // Memory not ready for 5 cycles: request fields must hold and nobody else is granted.
    mem_req_ready = 1'b0;
    ifu_src_q.push_back(32'h8000_0200);
    lsu_src_q.push_back('{wen: 1'b1, addr: 32'h8000_3000, wdata: 32'h1234_5678, wmask: 8'hA5});
    fork
      run_stream();
      begin
        b = 0;
        do begin @(negedge clk); b++; end while (!mem_req_valid && b < 50);
        check_eq("stall_head", 64'(exp_mreq_q.size() != 0), 64'd1);
        for (int s = 0; s < 5; s++) begin
          if (s != 0) @(negedge clk);
          check_eq("stall_valid", 64'(mem_req_valid), 64'd1);
          if (exp_mreq_q.size() != 0) begin
            check_eq("stall_addr", 64'(mem_req_addr), 64'(exp_mreq_q[0].addr));
            check_eq("stall_wmask", 64'(mem_req_wmask), 64'(exp_mreq_q[0].wmask));
          end
          check_eq("stall_no_grant", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
      end
    join
    wait_drain();

    // Watchdog: memory silent, error after TIMEOUT RSP cycles.
    drop_rsp = 1'b1;
    expect_timeout = 1'b1;
    ifu_src_q.push_back(32'h8000_0400);
    run_stream();
    wait_drain();
    drop_rsp = 1'b0;
    expect_timeout = 1'b0;

    // Orphaned response is absorbed in IDLE before the next grant.
    lsu_src_q.push_back('{wen: 1'b0, addr: 32'h8000_0500, wdata: 32'd0, wmask: 8'd0});
    fork
      run_stream();
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("orphan_no_grant", 64'(lsu_req_ready), 64'd0);
          check_eq("orphan_rsp_ready", 64'(mem_rsp_ready), 64'd1);
        end
        stray_req_cnt++;
      end
    join
    wait_drain();

    // Response held while the LSU stalls rsp_ready for 3 cycles.
    lsu_rsp_ready = 1'b0;
    lsu_src_q.push_back('{wen: 1'b0, addr: 32'h8000_0600, wdata: 32'd0, wmask: 8'd0});
    fork
      run_stream();
      begin
        b = 0;
        do begin @(negedge clk); b++; end while (!lsu_rsp_valid && b < 50);
        for (int s = 0; s < 3; s++) begin
          if (s != 0) @(negedge clk);
          check_eq("hold_valid", 64'(lsu_rsp_valid), 64'd1);
          check_eq("hold_rdata", 64'(lsu_rsp_rdata), 64'(mem_word(32'h8000_0600)));
        end
        @(posedge clk); #1;
        lsu_rsp_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-RSP: everything clears with no clock edge and no response is produced.
    drop_rsp = 1'b1;
    ifu_src_q.push_back(32'h8000_0700);
    run_stream();
    repeat (2) @(posedge clk);
    #3;
    check_eq("pre_reset_rsp_state", 64'(mem_rsp_ready), 64'd1);
    rst = 1'b0;
    #1;
    check_all_idle("async_reset");
    exp_rsp_q.delete();
    tb_last = MID_LSU;
    drop_rsp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    ifu_src_q.push_back(32'h8000_0800);
    lsu_src_q.push_back('{wen: 1'b0, addr: 32'h8000_0900, wdata: 32'd0, wmask: 8'd0});
    run_stream();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
